// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode and the
// per-opcode execute steps, driving datapath mux selects and write enables.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord_sel,
    output logic       reg_we,
    output logic [1:0] regdst_sel,
    output logic [1:0] memtoreg_sel,
    output logic       alusrca_sel,
    output logic [1:0] alusrcb_sel,
    output logic [1:0] pcsrc_sel,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;

    logic       pc_we_c, ir_we_c, mem_re_c, mem_we_c, iord_c, reg_we_c;
    logic [1:0] regdst_c, memtoreg_c, alusrcb_c, pcsrc_c, alu_op_c;
    logic       alusrca_c, done_c, illegal_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_we_c    = 1'b0;
        ir_we_c    = 1'b0;
        mem_re_c   = 1'b0;
        mem_we_c   = 1'b0;
        iord_c     = 1'b0;
        reg_we_c   = 1'b0;
        regdst_c   = 2'b00;
        memtoreg_c = 2'b00;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        pcsrc_c    = 2'b00;
        alu_op_c   = 2'b00;
        done_c     = 1'b0;
        illegal_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 and IR load both commit only in the cycle memory completes
                mem_re_c  = 1'b1;
                alusrcb_c = 2'b01;
                pc_we_c   = mem_ready;
                ir_we_c   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_re_c = 1'b1;
                iord_c   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we_c   = 1'b1;
                memtoreg_c = 2'b01;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_we_c = 1'b1;
                iord_c   = 1'b1;
                done_c   = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alusrca_c = 1'b1;
                alu_op_c  = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_c = 1'b1;
                regdst_c = 2'b01;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                alu_op_c  = 2'b01;
                pcsrc_c   = 2'b01;
                pc_we_c   = zero;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_we_c = 1'b1;
                pcsrc_c = 2'b10;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_we_c = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // link register takes the pre-update PC, which already holds PC+4
                reg_we_c   = 1'b1;
                regdst_c   = 2'b10;
                memtoreg_c = 2'b10;
                pc_we_c    = 1'b1;
                pcsrc_c    = 2'b10;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset silences every output immediately, abandoning any memory access in flight
    always_comb begin
        pc_we        = !rst && pc_we_c;
        ir_we        = !rst && ir_we_c;
        mem_re       = !rst && mem_re_c;
        mem_we       = !rst && mem_we_c;
        iord_sel     = !rst && iord_c;
        reg_we       = !rst && reg_we_c;
        regdst_sel   = rst ? 2'b00 : regdst_c;
        memtoreg_sel = rst ? 2'b00 : memtoreg_c;
        alusrca_sel  = !rst && alusrca_c;
        alusrcb_sel  = rst ? 2'b00 : alusrcb_c;
        pcsrc_sel    = rst ? 2'b00 : pcsrc_c;
        alu_op       = rst ? 2'b00 : alu_op_c;
        instr_done   = !rst && done_c;
        illegal      = !rst && illegal_c;
        state        = rst ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: each instruction is expanded into its expected per-cycle
// output trace, then replayed against the DUT with randomized waits, opcodes and resets.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_re, mem_we, iord_sel, reg_we;
    logic [1:0] regdst_sel, memtoreg_sel, alusrcb_sel, pcsrc_sel, alu_op;
    logic       alusrca_sel, instr_done, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
        .iord_sel(iord_sel), .reg_we(reg_we), .regdst_sel(regdst_sel),
        .memtoreg_sel(memtoreg_sel), .alusrca_sel(alusrca_sel),
        .alusrcb_sel(alusrcb_sel), .pcsrc_sel(pcsrc_sel), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    localparam int B_PCWE = 22, B_IRWE = 21, B_MRE = 20, B_MWE = 19, B_IORD = 18;
    localparam int B_RWE = 17, B_RDST = 15, B_MTR = 13, B_ASA = 12, B_ASB = 10;
    localparam int B_PCS = 8, B_ALU = 6, B_DONE = 5, B_ILL = 4;

    logic [22:0] act;
    assign act = {pc_we, ir_we, mem_re, mem_we, iord_sel, reg_we, regdst_sel, memtoreg_sel,
                  alusrca_sel, alusrcb_sel, pcsrc_sel, alu_op, instr_done, illegal, state};

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [22:0] exp;
        int          tag;
    } cyc_t;

    cyc_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [22:0] base(input logic [3:0] st);
        logic [22:0] v;
        v = '0;
        v[3:0] = st;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom);
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b000011, 6'b001000};
    endfunction

    task automatic push(input logic r, input logic [5:0] op, input logic mr,
                        input logic z, input logic [22:0] v);
        cyc_t c;
        c.r = r; c.op = op; c.mr = mr; c.z = z; c.exp = v; c.tag = 0;
        q.push_back(c);
    endtask

    task automatic check(input string name, input logic [22:0] a, input logic [22:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, a, e);
        end
    endtask

    // Expected trace of one instruction: fw fetch waits, mw data-memory waits.
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        logic [22:0] v;
        v = base(4'd0);
        v[B_MRE] = 1'b1;
        v[B_ASB +: 2] = 2'b01;
        for (int i = 0; i < fw; i++) push(1'b0, ro(), 1'b0, rb(), v);
        v[B_PCWE] = 1'b1;
        v[B_IRWE] = 1'b1;
        push(1'b0, ro(), 1'b1, rb(), v);

        v = base(4'd1);
        v[B_ASB +: 2] = 2'b11;
        v[B_ILL] = !legal_op(op);
        push(1'b0, op, rb(), rb(), v);
        if (!legal_op(op)) return;

        case (op)
            6'b000000: begin
                v = base(4'd6); v[B_ASA] = 1'b1; v[B_ALU +: 2] = 2'b10;
                push(1'b0, op, rb(), rb(), v);
                v = base(4'd7); v[B_RWE] = 1'b1; v[B_RDST +: 2] = 2'b01; v[B_DONE] = 1'b1;
                push(1'b0, op, rb(), rb(), v);
            end
            6'b100011, 6'b101011: begin
                v = base(4'd2); v[B_ASA] = 1'b1; v[B_ASB +: 2] = 2'b10;
                push(1'b0, op, rb(), rb(), v);
                if (op == 6'b100011) begin
                    v = base(4'd3); v[B_MRE] = 1'b1; v[B_IORD] = 1'b1;
                    for (int i = 0; i < mw; i++) push(1'b0, op, 1'b0, rb(), v);
                    push(1'b0, op, 1'b1, rb(), v);
                    v = base(4'd4); v[B_RWE] = 1'b1; v[B_MTR +: 2] = 2'b01; v[B_DONE] = 1'b1;
                    push(1'b0, op, rb(), rb(), v);
                end else begin
                    v = base(4'd5); v[B_MWE] = 1'b1; v[B_IORD] = 1'b1;
                    for (int i = 0; i < mw; i++) push(1'b0, op, 1'b0, rb(), v);
                    v[B_DONE] = 1'b1;
                    push(1'b0, op, 1'b1, rb(), v);
                end
            end
            6'b000100: begin
                v = base(4'd8); v[B_ASA] = 1'b1; v[B_ALU +: 2] = 2'b01;
                v[B_PCS +: 2] = 2'b01; v[B_PCWE] = z; v[B_DONE] = 1'b1;
                push(1'b0, op, rb(), z, v);
            end
            6'b000010: begin
                v = base(4'd9); v[B_PCWE] = 1'b1; v[B_PCS +: 2] = 2'b10; v[B_DONE] = 1'b1;
                push(1'b0, op, rb(), rb(), v);
            end
            6'b000011: begin
                v = base(4'd12); v[B_RWE] = 1'b1; v[B_RDST +: 2] = 2'b10;
                v[B_MTR +: 2] = 2'b10; v[B_PCWE] = 1'b1; v[B_PCS +: 2] = 2'b10;
                v[B_DONE] = 1'b1;
                push(1'b0, op, rb(), rb(), v);
            end
            default: begin
                v = base(4'd10); v[B_ASA] = 1'b1; v[B_ASB +: 2] = 2'b10;
                push(1'b0, op, rb(), rb(), v);
                v = base(4'd11); v[B_RWE] = 1'b1; v[B_DONE] = 1'b1;
                push(1'b0, op, rb(), rb(), v);
            end
        endcase
    endtask

    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst = c.r; opcode = c.op; mem_ready = c.mr; zero = c.z;
            #2;
            check("outputs", act, c.exp);
            case (c.tag)
                1: begin
                    check("first_state", 23'(state), 23'd0);
                    check("first_enables", 23'({mem_re, pc_we, ir_we}), 23'b111);
                end
                2: check("jal_fields", 23'({reg_we, regdst_sel, memtoreg_sel, pc_we, pcsrc_sel}),
                         23'b1_10_10_1_10);
                3: check("beq_taken", 23'({pc_we, pcsrc_sel}), 23'b1_01);
                4: check("beq_not_taken", 23'(pc_we), 23'd0);
                5: check("illegal_pulse", 23'({illegal, reg_we, mem_we, instr_done}), 23'b1000);
                6: check("rst_in_memwr", 23'({state, mem_we}), 23'd0);
                7: check("after_rst_state", 23'(state), 23'd0);
                default: ;
            endcase
        end
    endtask

    logic [5:0] ops [8];
    initial begin
        int idx, n, k;
        logic [22:0] v;
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b000010, 6'b000011, 6'b001000, 6'b111111};

        push(1'b1, ro(), rb(), rb(), 23'd0);
        push(1'b1, ro(), 1'b1, rb(), 23'd0);
        idx = q.size();
        do_instr(6'b000000, 0, 0, 1'b0);
        q[idx].tag = 1;
        do_instr(6'b100011, 0, 3, 1'b0);
        do_instr(6'b000100, 0, 0, 1'b1);
        q[q.size() - 1].tag = 3;
        do_instr(6'b000100, 0, 0, 1'b0);
        q[q.size() - 1].tag = 4;
        do_instr(6'b000011, 0, 0, 1'b0);
        q[q.size() - 1].tag = 2;
        do_instr(6'b111111, 0, 0, 1'b0);
        q[q.size() - 1].tag = 5;

        // sw interrupted by reset in the middle of its memory wait
        do_instr(6'b101011, 0, 2, 1'b0);
        void'(q.pop_back());
        push(1'b1, 6'b101011, 1'b0, rb(), 23'd0);
        q[q.size() - 1].tag = 6;
        idx = q.size();
        do_instr(6'b001000, 1, 0, 1'b0);
        q[idx].tag = 7;
        do_instr(6'b000010, 2, 0, 1'b0);
        run_queue();

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 5) == 0) ? ro() : ops[$urandom_range(0, 7)];
            idx = q.size();
            do_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
            if ($urandom_range(0, 9) == 0) begin
                n = q.size() - idx;
                k = int'($urandom_range(0, n - 1));
                while (q.size() > idx + k) void'(q.pop_back());
                push(1'b1, ro(), rb(), rb(), 23'd0);
                if (rb()) push(1'b1, ro(), rb(), rb(), 23'd0);
            end
            run_queue();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
